branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- ID-stage branch resolution, directly downstream of the branch comparator. Drives the comparator's 3-bit control code and consumes its 1-bit result. Turns the result into a PC redirect, an IF/ID flush and a hazard stall.
- Also resolves J/JAL (absolute) and JR/JALR (register) targets. Keeps wrapping branch statistics counters.

Parameters:
- CNT_W, 16, width of BranchCount and TakenCount.
- MAX_WAIT, 4, maximum consecutive operand-wait cycles before HazardTimeout is raised.

Ports:
- Clock  in  1  pipeline clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- BranchValid  in  1  conditional branch in ID this cycle.
- BranchType  in  3  000 BEQ, 001 BGEZ, 010 BGTZ, 011 BLEZ, 100 BLTZ, 101 BNE; 110/111 reserved.
- Jump  in  1  J/JAL in ID.
- JumpReg  in  1  JR/JALR in ID.
- RsBusy  in  1  Rs source is not yet forwardable (load in EX/MEM).
- RtBusy  in  1  Rt source is not yet forwardable.
- PC_ID  in  32  PC+4 of the ID instruction.
- Imm  in  32  sign-extended branch offset, in words.
- JumpIndex  in  26  instr[25:0].
- RegTarget  in  32  forwarded Rs value.
- CmpResult  in  1  comparator output; valid at the posedge ending the evaluating cycle.
- CmpControl  out  3  combinational copy of BranchType to the comparator.
- Stall  out  1  combinational; holds PC and IF/ID.
- Redirect  out  1  registered; selects TargetPC as next PC.
- Flush  out  1  registered; squashes IF/ID.
- TargetPC  out  32  registered redirect address.
- HazardTimeout  out  1  sticky error flag.
- BranchCount  out  CNT_W  resolved conditional branches.
- TakenCount  out  CNT_W  taken conditional branches.

Behaviour:
- Reset (asynchronous, Reset=0): state IDLE; Redirect, Flush, HazardTimeout = 0; TargetPC = 0; counters = 0; WaitCnt = 0. Reset mid-WAIT or mid-REDIRECT aborts immediately, and no redirect is issued after release.
- Request types:
  - A request is BranchValid | Jump | JumpReg.
  - Priority when several are set: JumpReg > Jump > BranchValid.
- Operand need:
  - Branch: BEQ and BNE need Rs and Rt; the other types need Rs only.
  - Jump: needs no operands.
  - JumpReg: needs Rs.
- IDLE:
  - Request with all needed operands ready: evaluate this cycle. Stall = 0.
    - Taken: TargetPC, Redirect=1 and Flush=1 are registered at the posedge; next state REDIRECT.
    - Not taken: remain in IDLE; Redirect stays 0.
  - Request with a needed operand busy: Stall = 1, WaitCnt = 1, next state WAIT.
- WAIT:
  - Stall = 1 while any needed operand is busy. WaitCnt increments each cycle.
  - If WaitCnt reaches MAX_WAIT with an operand still busy: set HazardTimeout (cleared only by reset). Stall stays asserted and the FSM stays in WAIT.
  - When all needed operands are ready: Stall = 0, evaluate exactly as in IDLE, then go to REDIRECT or IDLE. WaitCnt clears.
- REDIRECT (exactly one cycle):
  - Redirect=1 and Flush=1. Any request in ID is ignored because it is being squashed.
  - Next state IDLE; Redirect and Flush return to 0.
- Taken rules:
  - Branch: CmpResult. Reserved BranchType values are forced not-taken but still counted.
  - Jump and JumpReg: always taken.
- Targets (32-bit modulo arithmetic; overflow wraps, no flag):
  - Branch: PC_ID + (Imm << 2).
  - Jump: {PC_ID[31:28], JumpIndex, 2'b00}.
  - JumpReg: RegTarget. Bits [1:0] pass through unmodified.
- Latency: 1 cycle from the evaluating cycle to Redirect. Back-to-back not-taken branches can be resolved every cycle.
- Counters:
  - BranchCount increments on each resolved conditional branch only (jumps are not counted).
  - TakenCount increments on each taken conditional branch.
  - Both wrap from all-ones to 0.
- CmpControl always equals BranchType, including while stalled, so the comparator re-evaluates on fresh forwarded operands.

Test Plan:
- Reset=0 mid-WAIT, with RsBusy held -> all outputs 0 asynchronously. After release with BranchValid=0 -> state IDLE, Stall=0, no Redirect.
- BEQ, PC_ID=0x00400010, Imm=0xFFFFFFFC, CmpResult=1, no hazards -> the next cycle has Redirect=1, Flush=1, TargetPC=0x00400000 for exactly one cycle. BranchCount=1, TakenCount=1.
- BNE with CmpResult=0 on four consecutive cycles -> Redirect never asserts, Stall=0 throughout, BranchCount=4, TakenCount=0.
- BGTZ with RsBusy=1 for 2 cycles, then 0, CmpResult=1 -> Stall=1 for exactly 2 cycles, then a Redirect pulse. A second case: BLEZ with only RtBusy=1 -> Stall=0.
- J, PC_ID=0x90000004, JumpIndex=0x3FFFFFF -> TargetPC=0x9FFFFFFC. JumpReg and Jump both set, RegTarget=0x00400100 -> TargetPC=0x00400100. BranchCount unchanged in both cases.
- JumpReg with RsBusy held for 6 cycles, MAX_WAIT=4 -> HazardTimeout=1 after the 4th wait cycle and stays 1 after the Redirect. With CNT_W=16 and BranchCount preloaded to 0xFFFF via branches, one more branch -> BranchCount=0x0000.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Branch resolution bus: ID-stage request/operand signals in, redirect/stall/stats out.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             BranchValid;
  logic [2:0]       BranchType;
  logic             Jump;
  logic             JumpReg;
  logic             RsBusy;
  logic             RtBusy;
  logic [31:0]      PC_ID;
  logic [31:0]      Imm;
  logic [25:0]      JumpIndex;
  logic [31:0]      RegTarget;
  logic             CmpResult;
  logic [2:0]       CmpControl;
  logic             Stall;
  logic             Redirect;
  logic             Flush;
  logic [31:0]      TargetPC;
  logic             HazardTimeout;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] TakenCount;

  modport master (
    output BranchValid, BranchType, Jump, JumpReg, RsBusy, RtBusy,
           PC_ID, Imm, JumpIndex, RegTarget, CmpResult,
    input  CmpControl, Stall, Redirect, Flush, TargetPC, HazardTimeout,
           BranchCount, TakenCount
  );

  modport slave (
    input  BranchValid, BranchType, Jump, JumpReg, RsBusy, RtBusy,
           PC_ID, Imm, JumpIndex, RegTarget, CmpResult,
    output CmpControl, Stall, Redirect, Flush, TargetPC, HazardTimeout,
           BranchCount, TakenCount
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump resolver: stalls on unforwardable operands, issues a
// one-cycle registered redirect+flush, tracks hazard timeout and branch stats.
module branch_resolve_unit #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  branch_resolve_unit_if.slave  bus
);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIR} state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             redirect_q, flush_q, hazard_q;
  logic [31:0]      target_q;
  logic [CNT_W-1:0] bcnt_q, tcnt_q;

  logic        sel_jr, sel_j, sel_br, req;
  logic        need_rs, need_rt, busy;
  logic        type_ok, br_taken, taken;
  logic [31:0] target;
  logic        stall_c, resolve, hz_set;

  // Request decode: JumpReg beats Jump beats a conditional branch.
  always_comb begin
    sel_jr   = bus.JumpReg;
    sel_j    = ~bus.JumpReg & bus.Jump;
    sel_br   = ~bus.JumpReg & ~bus.Jump & bus.BranchValid;
    req      = sel_jr | sel_j | sel_br;
    need_rs  = sel_jr | sel_br;
    // Only the two-register compares (BEQ/BNE) look at Rt.
    need_rt  = sel_br & ((bus.BranchType == 3'b000) | (bus.BranchType == 3'b101));
    busy     = (need_rs & bus.RsBusy) | (need_rt & bus.RtBusy);
    type_ok  = (bus.BranchType <= 3'b101);
    br_taken = sel_br & type_ok & bus.CmpResult;
    taken    = sel_jr | sel_j | br_taken;
    if (sel_jr)
      target = bus.RegTarget;
    else if (sel_j)
      target = {bus.PC_ID[31:28], bus.JumpIndex, 2'b00};
    else
      target = bus.PC_ID + {bus.Imm[29:0], 2'b00};
  end

  // Next state, wait count and stall; REDIRECT ignores the squashed ID slot.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stall_c = 1'b0;
    resolve = 1'b0;
    unique case (state_q)
      S_IDLE, S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else if (busy) begin
          stall_c = 1'b1;
          state_d = S_WAIT;
          wait_d  = (wait_q == WMAX) ? wait_q : wait_q + 1'b1;
        end else begin
          resolve = 1'b1;
          wait_d  = '0;
          state_d = taken ? S_REDIR : S_IDLE;
        end
      end
      S_REDIR: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
    hz_set = stall_c & (wait_d == WMAX);
  end

  // FSM state and consecutive-wait counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Registered redirect outputs, sticky timeout flag and wrapping counters.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      target_q   <= '0;
      hazard_q   <= 1'b0;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      redirect_q <= resolve & taken;
      flush_q    <= resolve & taken;
      if (resolve & taken) target_q <= target;
      if (hz_set)          hazard_q <= 1'b1;
      if (resolve & sel_br)   bcnt_q <= bcnt_q + 1'b1;
      if (resolve & br_taken) tcnt_q <= tcnt_q + 1'b1;
    end
  end

  // Stall is gated by reset so an in-flight hazard cannot hold the pipe during reset.
  assign bus.Stall         = stall_c & Reset;
  assign bus.CmpControl    = bus.BranchType;
  assign bus.Redirect      = redirect_q;
  assign bus.Flush         = flush_q;
  assign bus.TargetPC      = target_q;
  assign bus.HazardTimeout = hazard_q;
  assign bus.BranchCount   = bcnt_q;
  assign bus.TakenCount    = tcnt_q;
endmodule
